enigma_rotor_ctrl: RTL
======================

// Module: enigma_rotor_ctrl
// PURPOSE
// Upstream feeder of the enigma_1 encoding pipeline. Accepts plaintext letters (1..26), steps the three
// rotors per letter (odometer carry via notches), and presents each letter registered together with the rotor
// positions to use for it. Supplies per-rotor delay lines so later encoder stages see the positions that match
// their in-flight letter.
// PARAMETERS
// R1_INIT_VALUE  1   rotor 1 (fast) position after reset, 1..LETTERS
// R2_INIT_VALUE  1   rotor 2 (middle) position after reset, 1..LETTERS
// R3_INIT_VALUE  1   rotor 3 (slow) position after reset, 1..LETTERS
// R1_NOTCH       17  rotor 1 position whose departure steps rotor 2
// R2_NOTCH       5   rotor 2 position whose departure steps rotor 3
// LETTERS        26  alphabet size; positions and letters are 1..LETTERS
// PORTS
// clk_i          in   1        clock
// rst_i          in   1        reset, asynchronous, active-high
// rotors_rst_i   in   1        sync: return rotor positions to R*_INIT_VALUE
// pos_load_i     in   1        sync: load positions from r*_load_i
// r1_load_i      in   7        rotor 1 load value
// r2_load_i      in   7        rotor 2 load value
// r3_load_i      in   7        rotor 3 load value
// in_symb_i      in   7        plaintext letter
// in_val_i       in   1        in_symb_i valid this cycle
// out_symb_o     out  7        registered letter -> encoder in_symb_i
// en_val_o       out  1        out_symb_o valid -> encoder en_val_i
// r1_o           out  7        rotor 1 position for out_symb_o
// r1_d_o         out  [5:1][7] r1_o delayed 1..5 cycles
// r2_o           out  7        rotor 2 position for out_symb_o
// r2_d_o         out  [4:1][7] r2_o delayed 1..4 cycles
// r3_o           out  7        rotor 3 position for out_symb_o
// r3_d_o         out  [3:1][7] r3_o delayed 1..3 cycles
// err_o          out  1        one-cycle pulse: rejected letter or load value
// BEHAVIOUR
// - rst_i (async): r1_o/r2_o/r3_o = R*_INIT_VALUE, every delay stage = its rotor's init value,
//   out_symb_o = 0, en_val_o = 0, err_o = 0.
// - Command priority per cycle: rotors_rst_i > pos_load_i > in_val_i. Lower-priority command in the same
//   cycle is dropped silently, with en_val_o = 0 and err_o = 0.
// - Accepted letter (in_val_i, 1 <= in_symb_i <= LETTERS): at the next edge, out_symb_o = in_symb_i,
//   en_val_o = 1, positions are the stepped values. Latency 1 cycle. No back-pressure; one letter per cycle.
// - Stepping before encode, based on pre-step values:
//   - r1 always steps.
//   - r2 steps if r1 == R1_NOTCH.
//   - r3 steps if r2 steps and r2 == R2_NOTCH.
//   - Step is +1 with LETTERS -> 1 wrap. Unsigned 7-bit arithmetic; no value outside 1..LETTERS is ever output.
// - Letter 0 or > LETTERS: no step, en_val_o = 0, err_o = 1 next cycle, out_symb_o holds.
// - pos_load_i: all three positions load next edge if every load value is in 1..LETTERS.
//   Otherwise positions hold and err_o = 1.
// - rotors_rst_i: positions = init values next edge; en_val_o = 0.
// - Idle cycles: en_val_o = 0; positions and out_symb_o hold.
// - Delay lines shift every cycle regardless of valid: d[1] <= r*_o, d[k] <= d[k-1].
//   Only rst_i clears them; rotors_rst_i and pos_load_i affect r*_o only.
// CONFIGURATION
// - ENIGMA_DOUBLE_STEP_EN defined: historical double-step.
//   - r2 additionally steps whenever r2 == R2_NOTCH on an accepted letter, independent of r1.
//   - That r2 step also steps r3.
// - Not defined: pure odometer carry as above.
// TESTING
// - Reset, no stimulus -> r1_o = r2_o = r3_o = 1, all d stages = 1, en_val_o = 0, out_symb_o = 0.
// - Letter 5 once -> next cycle out_symb_o = 5, en_val_o = 1, r1_o = 2, r2_o = 1, r3_o = 1.
//   Following cycle en_val_o = 0.
// - 26 letters back-to-back from 1,1,1 -> r1 wraps to 1, r2_o = 2 from letter 17 on, r3_o = 1;
//   r1_d_o[5] equals r1_o of 5 cycles earlier throughout.
// - Load 17,5,1 then a letter -> 18,6,2. Load 1,5,1 then a letter -> 2,6,2 with ENIGMA_DOUBLE_STEP_EN,
//   2,5,1 without.
// - in_symb_i = 27 valid -> err_o pulse, no step, en_val_o = 0. Load r2 = 0 -> err_o pulse, positions hold.
// - rotors_rst_i + in_val_i same cycle from 9,3,2 -> 1,1,1, en_val_o = 0. rst_i mid-stream -> all outputs at
//   reset values immediately.

Source files
------------

// File: rtl/enigma_rotor_ctrl.sv
// Rotor stepping front end for the enigma_1 pipeline: registers each letter with its stepped rotor positions
// and supplies per-rotor delay lines. Define ENIGMA_DOUBLE_STEP_EN for the historical middle-rotor double step.
module enigma_rotor_ctrl #(
    parameter int R1_INIT_VALUE = 1,
    parameter int R2_INIT_VALUE = 1,
    parameter int R3_INIT_VALUE = 1,
    parameter int R1_NOTCH      = 17,
    parameter int R2_NOTCH      = 5,
    parameter int LETTERS       = 26
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rotors_rst_i,
    input  logic            pos_load_i,
    input  logic [6:0]      r1_load_i,
    input  logic [6:0]      r2_load_i,
    input  logic [6:0]      r3_load_i,
    input  logic [6:0]      in_symb_i,
    input  logic            in_val_i,
    output logic [6:0]      out_symb_o,
    output logic            en_val_o,
    output logic [6:0]      r1_o,
    output logic [5:1][6:0] r1_d_o,
    output logic [6:0]      r2_o,
    output logic [4:1][6:0] r2_d_o,
    output logic [6:0]      r3_o,
    output logic [3:1][6:0] r3_d_o,
    output logic            err_o
);
    localparam logic [6:0] R1I = 7'(R1_INIT_VALUE);
    localparam logic [6:0] R2I = 7'(R2_INIT_VALUE);
    localparam logic [6:0] R3I = 7'(R3_INIT_VALUE);
    localparam logic [6:0] N1  = 7'(R1_NOTCH);
    localparam logic [6:0] N2  = 7'(R2_NOTCH);
    localparam logic [6:0] LTR = 7'(LETTERS);

    logic [6:0]      r1_q, r2_q, r3_q, symb_q;
    logic [6:0]      r1_d, r2_d, r3_d, symb_d;
    logic            en_q, en_d, err_q, err_d;
    logic [5:1][6:0] r1_dl_q;
    logic [4:1][6:0] r2_dl_q;
    logic [3:1][6:0] r3_dl_q;
    logic            r2_step, r3_step, letter_ok, load_ok;

    function automatic logic [6:0] step(input logic [6:0] p);
        return (p == LTR) ? 7'd1 : p + 7'd1;
    endfunction

    function automatic logic in_range(input logic [6:0] v);
        return (v != 7'd0) && (v <= LTR);
    endfunction

`ifdef ENIGMA_DOUBLE_STEP_EN
    // Middle rotor also kicks itself (and the slow rotor) off its own notch.
    assign r2_step = (r1_q == N1) || (r2_q == N2);
`else
    assign r2_step = (r1_q == N1);
`endif
    assign r3_step   = r2_step && (r2_q == N2);
    assign letter_ok = in_range(in_symb_i);
    assign load_ok   = in_range(r1_load_i) && in_range(r2_load_i) && in_range(r3_load_i);

    always_comb begin
        r1_d   = r1_q;
        r2_d   = r2_q;
        r3_d   = r3_q;
        symb_d = symb_q;
        en_d   = 1'b0;
        err_d  = 1'b0;
        if (rotors_rst_i) begin
            r1_d = R1I;
            r2_d = R2I;
            r3_d = R3I;
        end else if (pos_load_i) begin
            if (load_ok) begin
                r1_d = r1_load_i;
                r2_d = r2_load_i;
                r3_d = r3_load_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_val_i) begin
            if (letter_ok) begin
                r1_d   = step(r1_q);
                r2_d   = r2_step ? step(r2_q) : r2_q;
                r3_d   = r3_step ? step(r3_q) : r3_q;
                symb_d = in_symb_i;
                en_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r1_q    <= R1I;
            r2_q    <= R2I;
            r3_q    <= R3I;
            symb_q  <= 7'd0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            r1_dl_q <= {5{R1I}};
            r2_dl_q <= {4{R2I}};
            r3_dl_q <= {3{R3I}};
        end else begin
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            r3_q   <= r3_d;
            symb_q <= symb_d;
            en_q   <= en_d;
            err_q  <= err_d;
            // Delay lines free-run so each encoder stage sees the positions of its in-flight letter.
            r1_dl_q[1] <= r1_q;
            r2_dl_q[1] <= r2_q;
            r3_dl_q[1] <= r3_q;
            for (int k = 2; k <= 5; k++) r1_dl_q[k] <= r1_dl_q[k-1];
            for (int k = 2; k <= 4; k++) r2_dl_q[k] <= r2_dl_q[k-1];
            for (int k = 2; k <= 3; k++) r3_dl_q[k] <= r3_dl_q[k-1];
        end
    end

    assign out_symb_o = symb_q;
    assign en_val_o   = en_q;
    assign err_o      = err_q;
    assign r1_o       = r1_q;
    assign r2_o       = r2_q;
    assign r3_o       = r3_q;
    assign r1_d_o     = r1_dl_q;
    assign r2_d_o     = r2_dl_q;
    assign r3_d_o     = r3_dl_q;
endmodule
